// File: rtl/fib_run_ctrl.sv
// fib_run_ctrl: benchmark sequencer for the Fibonacci core.
// Holds the core in reset until a debounced button press. It then releases the
// core and counts RUN cycles until core_result equals EXPECTED, or aborts the
// run after TIMEOUT_CYCLES. It also keeps best-run and completed-run statistics.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset_n      asynchronous active-low reset
//   start_btn_n  raw active-low push button, asynchronous to clk
//   core_result  result word from the Fibonacci core
//   core_reset   active-high reset to the core (registered)
//   cycles       cycle count of the current or most recent run (registered)
//   best_cycles  minimum cycles over completed runs (registered)
//   run_count    number of completed runs, saturating at 255 (registered)
//   busy         high in HOLD and RUN (registered)
//   done         high in DONE (registered)
//   timeout      high in TIMEOUT (registered)
module fib_run_ctrl #(
    parameter logic [31:0] EXPECTED        = 32'd267914296,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CORE_RST_CYCLES = 4,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1000000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_btn_n,
    input  logic [31:0] core_result,
    output logic        core_reset,
    output logic [31:0] cycles,
    output logic [31:0] best_cycles,
    output logic [7:0]  run_count,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HD_W = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync2_q;
    logic              db_q, db_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic              core_reset_q, core_reset_d;
    logic [31:0]       cycles_q, cycles_d;
    logic [31:0]       best_q, best_d;
    logic [7:0]        run_count_q, run_count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              press_c;
    logic              match_c;

    // Debounce, press detection, sequencer and output next-state logic
    always_comb begin
        state_d      = state_q;
        db_d         = db_q;
        db_cnt_d     = db_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        cycles_d     = cycles_q;
        best_d       = best_q;
        run_count_d  = run_count_q;
        press_c      = 1'b0;
        match_c      = (core_result == EXPECTED);

        // A level is accepted once it has differed from the debounced value
        // for DEBOUNCE_CYCLES consecutive cycles.
        if (sync2_q == db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_d     = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end

        // Only the falling edge of the debounced level counts as a press
        press_c = db_q & ~db_d;

        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (press_c) begin
                    state_d    = ST_HOLD;
                    cycles_d   = '0;
                    hold_cnt_d = HD_W'(CORE_RST_CYCLES - 1);
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - HD_W'(1);
                end
            end
            ST_RUN: begin
                // Match has priority over timeout on the same cycle
                if (match_c) begin
                    state_d     = ST_DONE;
                    best_d      = (cycles_q < best_q) ? cycles_q : best_q;
                    run_count_d = (run_count_q == 8'hFF) ? run_count_q : run_count_q + 8'd1;
                end else if (cycles_q == TIMEOUT_CYCLES - 32'd1) begin
                    state_d  = ST_TIMEOUT;
                    cycles_d = cycles_q + 32'd1;
                end else begin
                    cycles_d = cycles_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs follow the next state so they switch with it
        core_reset_d = (state_d == ST_IDLE) || (state_d == ST_HOLD) || (state_d == ST_TIMEOUT);
        busy_d       = (state_d == ST_HOLD) || (state_d == ST_RUN);
        done_d       = (state_d == ST_DONE);
        timeout_d    = (state_d == ST_TIMEOUT);
    end

    // State and output registers, including the button synchronizer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            db_q         <= 1'b1;
            db_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            core_reset_q <= 1'b1;
            cycles_q     <= '0;
            best_q       <= 32'hFFFF_FFFF;
            run_count_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= start_btn_n;
            sync2_q      <= sync1_q;
            db_q         <= db_d;
            db_cnt_q     <= db_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            core_reset_q <= core_reset_d;
            cycles_q     <= cycles_d;
            best_q       <= best_d;
            run_count_q  <= run_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign cycles      = cycles_q;
    assign best_cycles = best_q;
    assign run_count   = run_count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_fib_run_ctrl.sv
// Self-checking bench for fib_run_ctrl with small simulation parameters.
// Runs are described at transaction level (which RUN cycle matches, when to
// press mid-run, when to pull reset) and compared to a statistics model.
module tb_fib_run_ctrl;

    localparam logic [31:0] EXP_VAL  = 32'd55;
    localparam int unsigned DEB      = 4;
    localparam int unsigned HOLD_LEN = 2;
    localparam int          TMO      = 100;

    logic        clk;
    logic        reset_n;
    logic        start_btn_n;
    logic [31:0] core_result;
    logic        core_reset;
    logic [31:0] cycles;
    logic [31:0] best_cycles;
    logic [7:0]  run_count;
    logic        busy;
    logic        done;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    // Reference statistics
    logic [31:0] m_best  = 32'hFFFF_FFFF;
    int          m_count = 0;

    // Button driver bookkeeping
    int btn_low_left = 0;
    int btn_high_cnt = 0;

    fib_run_ctrl #(
        .EXPECTED        (EXP_VAL),
        .DEBOUNCE_CYCLES (DEB),
        .CORE_RST_CYCLES (HOLD_LEN),
        .TIMEOUT_CYCLES  (32'(TMO))
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_btn_n (start_btn_n),
        .core_result (core_result),
        .core_reset  (core_reset),
        .cycles      (cycles),
        .best_cycles (best_cycles),
        .run_count   (run_count),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and update the button driver
    task automatic step();
        @(negedge clk);
        if (btn_low_left > 0) begin
            btn_low_left--;
            if (btn_low_left == 0) start_btn_n = 1'b1;
        end
        if (start_btn_n) btn_high_cnt++;
        else btn_high_cnt = 0;
    endtask

    task automatic press(input int low_len);
        while (btn_high_cnt < 12) step();
        start_btn_n  = 1'b0;
        btn_low_left = low_len;
        btn_high_cnt = 0;
    endtask

    function automatic logic [31:0] nonmatch();
        logic [31:0] r;
        if ($urandom_range(0, 3) == 0) r = EXP_VAL ^ (32'd1 << $urandom_range(0, 31));
        else r = $urandom;
        if (r == EXP_VAL) r = r ^ 32'h8000_0000;
        return r;
    endfunction

    function automatic logic [31:0] flags(input logic b, input logic cr, input logic d, input logic t);
        return {28'd0, b, cr, d, t};
    endfunction

    // One run: match_at = RUN cycle whose result matches (0 = never),
    // press_at = RUN cycle on which the button is pressed again (0 = none),
    // abort_at = RUN cycle after which reset_n is pulsed (0 = none).
    task automatic do_run(input int match_at, input int press_at, input int abort_at);
        int  hold_seen;
        bit  in_run;
        bit  finished;
        int  n;
        hold_seen = 0;
        in_run    = 1'b0;
        finished  = 1'b0;
        core_result = nonmatch();
        press(10);
        for (int k = 0; k < 40 && !in_run; k++) begin
            step();
            if (busy && core_reset) hold_seen++;
            else if (busy && !core_reset) in_run = 1'b1;
        end
        check("run_entry", 32'(in_run), 32'd1);
        check("hold_len", 32'(hold_seen), 32'(HOLD_LEN));
        n = 0;
        while (in_run && !finished && n < TMO + 5) begin
            n++;
            core_result = (n == match_at) ? EXP_VAL : nonmatch();
            if (n == press_at) begin
                start_btn_n  = 1'b0;
                btn_low_left = 10;
                btn_high_cnt = 0;
            end
            step();
            if (n == match_at) begin
                finished = 1'b1;
                if (32'(n - 1) < m_best) m_best = 32'(n - 1);
                if (m_count < 255) m_count++;
                check("done_flags", flags(busy, core_reset, done, timeout), 32'h2);
                check("done_cycles", cycles, 32'(n - 1));
                check("done_best", best_cycles, m_best);
                check("done_count", 32'(run_count), 32'(m_count));
                core_result = nonmatch();
                step();
                check("done_frozen", cycles, 32'(n - 1));
            end else if (n == TMO) begin
                finished = 1'b1;
                check("tmo_flags", flags(busy, core_reset, done, timeout), 32'h5);
                check("tmo_cycles", cycles, 32'(TMO));
                check("tmo_best", best_cycles, m_best);
                check("tmo_count", 32'(run_count), 32'(m_count));
            end else begin
                check("run_flags", flags(busy, core_reset, done, timeout), 32'h8);
                check("run_cycles", cycles, 32'(n));
                if (n == abort_at) begin
                    reset_n = 1'b0;
                    #1;
                    m_best  = 32'hFFFF_FFFF;
                    m_count = 0;
                    check("abort_flags", flags(busy, core_reset, done, timeout), 32'h4);
                    check("abort_cycles", cycles, 32'd0);
                    check("abort_best", best_cycles, m_best);
                    check("abort_count", 32'(run_count), 32'(m_count));
                    step();
                    reset_n = 1'b1;
                    finished = 1'b1;
                end
            end
        end
        if (in_run) check("run_end", 32'(finished), 32'd1);
    endtask

    initial begin
        reset_n     = 1'b0;
        start_btn_n = 1'b1;
        core_result = 32'd0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("rst_flags", flags(busy, core_reset, done, timeout), 32'h4);
        check("rst_cycles", cycles, 32'd0);
        check("rst_best", best_cycles, 32'hFFFF_FFFF);
        check("rst_count", 32'(run_count), 32'd0);

        // Short glitch must not start a run
        press(3);
        repeat (15) step();
        check("glitch_idle", flags(busy, core_reset, done, timeout), 32'h4);

        do_run(37, 0, 0);
        do_run(21, 0, 0);
        do_run(51, 0, 0);
        do_run(1, 0, 0);
        do_run(0, 0, 0);
        do_run(100, 30, 0);
        for (int i = 0; i < 6; i++) do_run(int'($urandom_range(1, 99)), 0, 0);
        do_run(0, 0, 40);

        for (int i = 0; i < 256; i++) do_run(int'($urandom_range(1, 6)), 0, 0);
        check("sat_count", 32'(run_count), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
